// File: rtl/pq_request_scheduler.sv
// pq_request_scheduler
// Front-end for the register-tree priority queue. Arbitrates independent
// enqueue and dequeue request streams into single-cycle enqueue, dequeue or
// replace commands, then holds off for SETTLE_CYCLES so the tree can finish
// its compare-and-swap passes. Dequeued/replaced roots land in a one-entry
// result register with a valid/ready handshake.
//
// Optional feature macro: PQ_SCHED_ZERO_FILTER_EN
//   When defined, zero keys are swallowed instead of being written to the
//   queue (0 is the queue's empty marker) and o_zero_drop pulses.
module pq_request_scheduler #(
   parameter int DATA_WIDTH    = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  i_CLK,
   input  logic                  i_RSTn,
   input  logic                  i_enq_valid,
   input  logic [DATA_WIDTH-1:0] i_enq_data,
   output logic                  o_enq_ready,
   input  logic                  i_deq_valid,
   output logic                  o_deq_ready,
   output logic                  o_res_valid,
   output logic [DATA_WIDTH-1:0] o_res_data,
   input  logic                  i_res_ready,
   output logic                  o_wrt,
   output logic                  o_read,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic                  i_full,
   input  logic                  i_empty,
   input  logic [DATA_WIDTH-1:0] i_top,
   output logic                  o_zero_drop
);

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

   state_t                  state;
   logic [7:0]              settle_cnt;
   logic                    res_valid;
   logic [DATA_WIDTH-1:0]   res_data;

   logic                    can_issue;
   logic                    slot_free;
   logic                    zero_key;
   logic                    do_replace;
   logic                    do_dequeue;
   logic                    do_enqueue;
   logic                    wrt;
   logic                    read;
   logic                    issue;
   logic                    drop_zero;

   // Commands only go out from IDLE, and never while reset is held, so every
   // combinational output is forced low during reset.
   assign can_issue = i_RSTn && (state == IDLE);
   assign slot_free = !res_valid || i_res_ready;

`ifdef PQ_SCHED_ZERO_FILTER_EN
   assign zero_key  = (i_enq_data == '0);
`else
   assign zero_key  = 1'b0;
`endif

   // Priority arbitration: replace, then dequeue, then enqueue.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      do_replace = 1'b0;
      do_dequeue = 1'b0;
      do_enqueue = 1'b0;
      if (can_issue) begin
         if (i_enq_valid && i_deq_valid && !i_empty && slot_free) begin
            do_replace = 1'b1;
         end else if (i_deq_valid && !i_empty && slot_free) begin
            do_dequeue = 1'b1;
         end else if (i_enq_valid && !i_full) begin
            do_enqueue = 1'b1;
         end
      end
   end

   // A filtered zero key is still consumed but never reaches the queue; a
   // zero replace therefore collapses into a plain dequeue.
   assign wrt       = (do_replace || do_enqueue) && !zero_key;
   assign read      = do_replace || do_dequeue;
   assign drop_zero = (do_replace || do_enqueue) && zero_key;
   assign issue     = wrt || read;

   assign o_wrt       = wrt;
   assign o_read      = read;
   assign o_data      = wrt ? i_enq_data : '0;
   assign o_enq_ready = do_replace || do_enqueue;
   assign o_deq_ready = do_replace || do_dequeue;

   // Settle sequencer: after an issued command, idle for SETTLE_CYCLES cycles.
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state      <= IDLE;
         settle_cnt <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            IDLE: begin
               if (issue && (SETTLE_LOAD != 8'd0)) begin
                  state      <= SETTLE;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - 8'd1;
               if (settle_cnt == 8'd1) begin
                  state <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               settle_cnt <= '0;
            end
         endcase
      end
   end

   // Result register: a new root capture takes precedence over a drain.
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         res_valid <= 1'b0;
         res_data  <= '0;
      end else if (read) begin
         res_valid <= 1'b1;
         res_data  <= i_top;
      end else if (res_valid && i_res_ready) begin
         res_valid <= 1'b0;
      end
   end

   assign o_res_valid = res_valid;
   assign o_res_data  = res_data;

`ifdef PQ_SCHED_ZERO_FILTER_EN
   logic zero_drop_q;

   // One-cycle registered pulse for every discarded zero key.
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         zero_drop_q <= 1'b0;
      end else begin
         zero_drop_q <= drop_zero;
      end
   end

   assign o_zero_drop = zero_drop_q;
`else
   assign o_zero_drop = 1'b0;

   // Without the filter the drop indication is structurally unused.
   logic unused_drop;
   assign unused_drop = drop_zero;
`endif

endmodule
